fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_pkg.sv | 15 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/fetch_buffer.sv | 106 ++++++++++
 tb/tb_fetch_buffer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch buffer.
// The {pc, inst} entry layout is common to the buffer control and its storage.
package fetch_pkg;

  localparam int          FETCH_DEPTH    = 4;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam int          PC_W           = 32;
  localparam int          INST_W         = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush, registered count and show-ahead head output.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_push_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // NOTE: the data array has no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: credit-limited requests, in-order responses, redirect flush.
// Define FETCH_BUF_BYPASS_EN to forward a response straight to out_* when the queue is empty.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = FETCH_DEPTH,
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_resp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop;

  logic [CW-1:0]   w_count;
  logic [CW:0]     w_used;
  logic            w_fifo_empty;
  logic            w_rsp_live;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;
  logic [PC_W-1:0] w_redirect_aligned;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_out_entry;

  // Credits cover both queued entries and every response still in flight, stale or not.
  assign w_used     = {1'b0, w_count} + {1'b0, r_outstanding};
  assign imem_req   = rst && !redirect && (w_used < (CW+1)'(DEPTH));
  assign imem_addr  = imem_req ? r_fetch_pc : '0;

  assign w_rsp_live = rst && imem_rvalid && (r_drop == '0) && !redirect;

`ifdef FETCH_BUF_BYPASS_EN
  assign w_bypass = w_rsp_live && w_fifo_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push       = w_rsp_live && !(w_bypass && out_ready);
  assign w_pop        = !w_fifo_empty && out_ready;
  assign w_push_entry = '{pc: r_resp_pc, inst: imem_rdata};
  assign w_redirect_aligned = {redirect_pc[PC_W-1:2], 2'b00};

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .i_flush     (redirect),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_empty     (w_fifo_empty)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_out_entry = '0;
    if (!w_fifo_empty)  w_out_entry = w_head;
    else if (w_bypass)  w_out_entry = w_push_entry;
  end

  assign out_valid = !w_fifo_empty || w_bypass;
  assign out_pc    = w_out_entry.pc;
  assign out_inst  = w_out_entry.inst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (redirect) begin
      // A response returning this cycle is already gone; everything else in flight is stale.
      r_fetch_pc    <= w_redirect_aligned;
      r_resp_pc     <= w_redirect_aligned;
      r_outstanding <= r_outstanding - CW'(imem_rvalid);
      r_drop        <= r_outstanding - CW'(imem_rvalid);
    end else begin
      if (imem_req)   r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_rsp_live) r_resp_pc  <= r_resp_pc + 32'd4;
      r_outstanding <= r_outstanding + CW'(imem_req) - CW'(imem_rvalid);
      if (imem_rvalid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: in-order memory model plus queue-based reference model.
// Honors FETCH_BUF_BYPASS_EN to pick the matching expectations.
module tb_fetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_ready   (out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Memory: in-order responses, one per cycle, latency in [lat_lo, lat_hi].
  typedef struct { logic [31:0] data; int due; } mreq_t;
  mreq_t mem_q[$];
  int    cyc = 0;
  int    last_due = -1;
  int    lat_lo = 1;
  int    lat_hi = 1;
  bit    mem_pause = 1'b0;

  // Reference model: the queue holds exactly what IF/ID should see next.
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        m_q[$];
  int          m_inflight = 0;
  int          m_drop = 0;
  logic [31:0] m_fetch = RESET_PC;
  logic [31:0] m_resp  = RESET_PC;

  logic [31:0] obs_q[$];
  logic        s_req, s_valid, s_rvalid;
  logic [31:0] s_addr, s_pc, s_inst;

  task automatic step();
    logic        e_req, e_valid;
    logic [31:0] e_addr, e_pc, e_inst;
    bit          live, byp_now;
    ent_t        e;
    int          due;
    if (!mem_pause && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    live = 1'b0;
    byp_now = 1'b0;
    if (!rst) begin
      m_q.delete();
      m_inflight = 0; m_drop = 0; m_fetch = RESET_PC; m_resp = RESET_PC;
      e_req = 1'b0; e_addr = '0; e_valid = 1'b0; e_pc = '0; e_inst = '0;
    end else begin
      live    = imem_rvalid && m_drop == 0 && !redirect;
      byp_now = BYP && live && m_q.size() == 0;
      e_valid = m_q.size() > 0 || byp_now;
      e_pc    = m_q.size() > 0 ? m_q[0].pc   : (byp_now ? m_resp : 32'h0);
      e_inst  = m_q.size() > 0 ? m_q[0].inst : (byp_now ? imem_rdata : 32'h0);
      e_req   = !redirect && (m_q.size() + m_inflight < DEPTH);
      e_addr  = m_fetch;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = out_valid;
    s_pc = out_pc; s_inst = out_inst; s_rvalid = imem_rvalid;
    n_checks++;
    if (imem_req !== e_req) begin
      n_fail++; $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_req, e_req);
    end
    if (e_req || !rst) begin
      n_checks++;
      if (imem_addr !== e_addr) begin
        n_fail++; $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, e_addr);
      end
    end
    n_checks++;
    if (out_valid !== e_valid || out_pc !== e_pc || out_inst !== e_inst) begin
      n_fail++;
      $display("FAIL out cyc=%0d got v=%b pc=%h inst=%h exp v=%b pc=%h inst=%h",
               cyc, out_valid, out_pc, out_inst, e_valid, e_pc, e_inst);
    end
    if (rst && out_valid && out_ready) obs_q.push_back(out_pc);
    if (rst && imem_req) begin
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      mem_q.push_back('{data: $urandom, due: due});
      last_due = due;
    end
    if (rst) begin
      if (redirect) begin
        if (imem_rvalid) m_inflight--;
        m_drop = m_inflight;
        m_q.delete();
        m_fetch = redirect_pc;
        m_resp  = redirect_pc;
      end else begin
        if (e_valid && out_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (imem_rvalid) begin
          m_inflight--;
          if (m_drop > 0) m_drop--;
          else begin
            if (!(byp_now && out_ready)) begin
              e.pc = m_resp; e.inst = imem_rdata;
              m_q.push_back(e);
            end
            m_resp = m_resp + 32'd4;
          end
        end
        if (e_req) begin m_inflight++; m_fetch = m_fetch + 32'd4; end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect = 1'b0; out_ready = 1'b0; mem_pause = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (i >= 2 && mem_q.size() == 0) break;
    end
    rst = 1'b1;
    obs_q.delete();
  endtask

  task automatic check_obs(input string name, input int k, input logic [31:0] exp);
    n_checks++;
    if (obs_q.size() <= k) begin
      n_fail++; $display("FAIL %s[%0d] got=<none> exp=%h", name, k, exp);
    end else if (obs_q[k] !== exp) begin
      n_fail++; $display("FAIL %s[%0d] got=%h exp=%h", name, k, obs_q[k], exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; lat_lo = 1; lat_hi = 1;
    step();
    n_checks++;
    if ({s_req, s_addr, s_valid, s_pc, s_inst} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got req=%b addr=%h v=%b pc=%h inst=%h exp all 0",
                         s_req, s_addr, s_valid, s_pc, s_inst);
    end
    do_reset();
    step();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
      n_fail++; $display("FAIL reset_release_req got req=%b addr=%h exp req=1 addr=%h", s_req, s_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int first_rv = -1;
    lat_lo = 1; lat_hi = 1;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (s_rvalid && first_rv < 0) begin
        first_rv = i;
`ifndef FETCH_BUF_BYPASS_EN
        n_checks++;
        if (s_valid !== 1'b0) begin
          n_fail++; $display("FAIL stream_store_first got out_valid=%b exp=0", s_valid);
        end
`endif
      end else if (first_rv >= 0 && i == first_rv + 1 && !BYP) begin
        n_checks++;
        if (s_valid !== 1'b1 || s_pc !== RESET_PC) begin
          n_fail++; $display("FAIL stream_first_out got v=%b pc=%h exp v=1 pc=%h", s_valid, s_pc, RESET_PC);
        end
      end
    end
    for (int k = 0; k < 8; k++) check_obs("stream_order", k, RESET_PC + 32'(4 * k));
  endtask

  task automatic test_stall();
    int n_req = 0;
    lat_lo = 1; lat_hi = 1;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_req) n_req++;
    end
    n_checks++;
    if (n_req != DEPTH || s_req !== 1'b0) begin
      n_fail++; $display("FAIL stall_credit got reqs=%0d last_req=%b exp reqs=%0d last_req=0", n_req, s_req, DEPTH);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    for (int k = 0; k < DEPTH; k++) check_obs("stall_order", k, RESET_PC + 32'(4 * k));
  endtask

  task automatic test_redirect_stale();
    lat_lo = 3; lat_hi = 3;
    do_reset();
    out_ready = 1'b1;
    step();
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    n_checks++;
    if (s_req !== 1'b0) begin
      n_fail++; $display("FAIL redirect_no_req got req=%b exp=0", s_req);
    end
    redirect = 1'b0;
    obs_q.delete();
    step();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h100 || s_valid !== 1'b0) begin
      n_fail++; $display("FAIL redirect_refetch got req=%b addr=%h v=%b exp req=1 addr=100 v=0", s_req, s_addr, s_valid);
    end
    for (int i = 0; i < 15; i++) step();
    check_obs("redirect_stale", 0, 32'h100);
    check_obs("redirect_stale", 1, 32'h104);
  endtask

  task automatic test_redirect_coincident();
    lat_lo = 1; lat_hi = 1;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
`ifndef FETCH_BUF_BYPASS_EN
    n_checks++;
    if (s_valid !== 1'b1) begin
      n_fail++; $display("FAIL coincident_pop got out_valid=%b exp=1", s_valid);
    end
`endif
    redirect = 1'b0;
    obs_q.delete();
    step();
    n_checks++;
    if (s_valid !== 1'b0) begin
      n_fail++; $display("FAIL coincident_flush got out_valid=%b exp=0", s_valid);
    end
    for (int i = 0; i < 8; i++) step();
    check_obs("coincident_next", 0, 32'h200);
    check_obs("coincident_next", 1, 32'h204);
  endtask

  task automatic test_reset_mid();
    bit reached = 1'b0;
    lat_lo = 3; lat_hi = 3;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_q.size() == 2) begin reached = 1'b1; break; end
      step();
    end
    n_checks++;
    if (!reached) begin
      n_fail++; $display("FAIL reset_mid_setup got buffered=%0d exp=2", m_q.size());
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({s_req, s_addr, s_valid, s_pc, s_inst} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs got req=%b addr=%h v=%b pc=%h inst=%h exp all 0",
                         s_req, s_addr, s_valid, s_pc, s_inst);
    end
    for (int i = 0; i < 20; i++) begin
      if (i >= 3 && mem_q.size() == 0) break;
      step();
    end
    rst = 1'b1;
    out_ready = 1'b1;
    obs_q.delete();
    step();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
      n_fail++; $display("FAIL reset_mid_release got req=%b addr=%h exp req=1 addr=%h", s_req, s_addr, RESET_PC);
    end
    for (int i = 0; i < 15; i++) step();
    check_obs("reset_mid_order", 0, RESET_PC);
    check_obs("reset_mid_order", 1, RESET_PC + 32'd4);
  endtask

  task automatic test_bypass();
    lat_lo = 1; lat_hi = 1;
    do_reset();
    out_ready = 1'b1;
    step();
    mem_q[0].data = 32'h0050_0093;
    step();
`ifdef FETCH_BUF_BYPASS_EN
    n_checks++;
    if (s_valid !== 1'b1 || s_inst !== 32'h0050_0093 || s_pc !== RESET_PC) begin
      n_fail++; $display("FAIL bypass_same_cycle got v=%b pc=%h inst=%h exp v=1 pc=%h inst=00500093", s_valid, s_pc, s_inst, RESET_PC);
    end
    mem_pause = 1'b1;
    step();
    n_checks++;
    if (s_valid !== 1'b0) begin
      n_fail++; $display("FAIL bypass_not_stored got out_valid=%b exp=0", s_valid);
    end
    mem_pause = 1'b0;
`else
    n_checks++;
    if (s_valid !== 1'b0) begin
      n_fail++; $display("FAIL store_same_cycle got out_valid=%b exp=0", s_valid);
    end
    step();
    n_checks++;
    if (s_valid !== 1'b1 || s_inst !== 32'h0050_0093 || s_pc !== RESET_PC) begin
      n_fail++; $display("FAIL store_next_cycle got v=%b pc=%h inst=%h exp v=1 pc=%h inst=00500093", s_valid, s_pc, s_inst, RESET_PC);
    end
`endif
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_random();
    lat_lo = 1; lat_hi = 4;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      out_ready   = ($urandom_range(3, 0) != 0);
      redirect    = ($urandom_range(15, 0) == 0);
      redirect_pc = {$urandom} & 32'hFFFF_FFFC;
      step();
    end
    redirect = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stale();
    test_redirect_coincident();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
